// File: rtl/onehot_hit_monitor_pkg.sv
// Shared widths, FSM state encoding and one-hot classification for the hit monitor.
package onehot_hit_monitor_pkg;

  localparam int DEC_N = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_MON   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO  = 2'd0,
    CLS_ONE   = 2'd1,
    CLS_MULTI = 2'd2
  } cls_t;

  // Map a bit count of the decoder word onto its legality class.
  function automatic cls_t classify(input logic [3:0] pc);
    if (pc == 4'd0)      return CLS_ZERO;
    else if (pc == 4'd1) return CLS_ONE;
    else                 return CLS_MULTI;
  endfunction

endpackage

// File: rtl/onehot_hit_monitor_if.sv
// Decoder-side stream, clear, read-back handshake and status outputs of the hit monitor.
interface onehot_hit_monitor_if #(parameter int CNT_W = 8);
  import onehot_hit_monitor_pkg::*;

  logic             in_valid;
  logic [DEC_N-1:0] dec_in;
  logic             clr;
  logic             rd_req;
  logic [SEL_W-1:0] rd_sel;
  logic             enc_valid;
  logic [SEL_W-1:0] enc_out;
  logic             err_multi;
  logic             err_zero;
  logic [CNT_W-1:0] err_count;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             fault;

  modport master (
    output in_valid, dec_in, clr, rd_req, rd_sel,
    input  enc_valid, enc_out, err_multi, err_zero, err_count, rd_valid, rd_data, fault
  );

  modport slave (
    input  in_valid, dec_in, clr, rd_req, rd_sel,
    output enc_valid, enc_out, err_multi, err_zero, err_count, rd_valid, rd_data, fault
  );

endinterface

// File: rtl/onehot_hit_monitor_enc8.sv
// Combinational 8->3 encoder with zero / one / multi classification of the input word.
module onehot_enc8
  import onehot_hit_monitor_pkg::*;
(
  input  logic [DEC_N-1:0] dec,
  output logic [SEL_W-1:0] idx,
  output cls_t             cls
);

  logic [3:0] pc;

  // Count set bits; on a multi-hot word the lowest set bit ends up in idx (it is discarded anyway).
  always_comb begin
    idx = '0;
    pc  = '0;
    for (int i = DEC_N - 1; i >= 0; i--) begin
      if (dec[i]) begin
        idx = SEL_W'(i);
        pc  = pc + 4'd1;
      end
    end
    cls = classify(pc);
  end

endmodule

// File: rtl/onehot_hit_monitor.sv
// Checks the decoder's one-hot output, re-encodes it, counts hits per line and serves counter reads.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_MON   | normal monitoring, legal words bump their hit counter
//  ST_FAULT | illegal word seen; hit counters frozen, enc_valid held 0,
//           | err_count still counts; left only through clr
module onehot_hit_monitor
  import onehot_hit_monitor_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_hit_monitor_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [DEC_N];
  state_t           state;
  logic             rd_pend;
  logic [SEL_W-1:0] rd_sel_q;
  logic [SEL_W-1:0] enc_idx;
  cls_t             enc_cls;
  logic             legal;
  logic             illegal;

  onehot_enc8 u_enc (
    .dec (bus.dec_in),
    .idx (enc_idx),
    .cls (enc_cls)
  );

  assign legal     = bus.in_valid && (enc_cls == CLS_ONE);
  assign illegal   = bus.in_valid && (enc_cls != CLS_ONE);
  assign bus.fault = (state == ST_FAULT);

  // FSM, hit counters, sticky flags, encoder register and the two-stage read pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_MON;
      for (int i = 0; i < DEC_N; i++) cnt[i] <= '0;
      bus.enc_valid <= 1'b0;
      bus.enc_out   <= '0;
      bus.err_multi <= 1'b0;
      bus.err_zero  <= 1'b0;
      bus.err_count <= '0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
      rd_pend       <= 1'b0;
      rd_sel_q      <= '0;
    end else begin
      bus.enc_valid <= legal && (state == ST_MON);
      if (legal) bus.enc_out <= enc_idx;

      if (bus.clr) begin
        state         <= ST_MON;
        for (int i = 0; i < DEC_N; i++) cnt[i] <= '0;
        bus.err_multi <= 1'b0;
        bus.err_zero  <= 1'b0;
        bus.err_count <= '0;
      end else if (illegal) begin
        if (enc_cls == CLS_ZERO) bus.err_zero  <= 1'b1;
        else                     bus.err_multi <= 1'b1;
        if (bus.err_count != CNT_MAX) bus.err_count <= bus.err_count + CNT_W'(1);
        if (STOP_ON_ERR) state <= ST_FAULT;
      end else if (legal && (state == ST_MON) && (cnt[enc_idx] != CNT_MAX)) begin
        cnt[enc_idx] <= cnt[enc_idx] + CNT_W'(1);
      end

      // Reading one cycle after the request returns the counter as it stood after the request edge.
      rd_pend      <= bus.rd_req;
      if (bus.rd_req) rd_sel_q <= bus.rd_sel;
      bus.rd_valid <= rd_pend;
      if (rd_pend) bus.rd_data <= cnt[rd_sel_q];
    end
  end

endmodule

// File: tb/tb_onehot_hit_monitor.sv
module tb_onehot_hit_monitor;
  import onehot_hit_monitor_pkg::*;

  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  onehot_hit_monitor_if #(.CNT_W(CW)) bus ();

  onehot_hit_monitor #(.CNT_W(CW), .STOP_ON_ERR(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: what each output should read after the latest edge.
  int m_cnt [8];
  bit m_fault, m_em, m_ez, m_ev, m_rv, m_pend;
  int m_ec, m_eo, m_rd, m_psel;

  typedef struct {
    logic [7:0] din;
    int         exp_idx;
  } vec_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  snap [8];
    int  pc, ix;
    bit  legal;
    snap = m_cnt;
    if (!rst) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_fault = 0; m_em = 0; m_ez = 0; m_ec = 0; m_ev = 0; m_eo = 0;
      m_rv = 0; m_rd = 0; m_pend = 0; m_psel = 0;
      return;
    end
    pc = $countones(bus.dec_in);
    ix = 0;
    for (int i = 0; i < 8; i++) if (bus.dec_in[i]) ix = i;
    legal = bus.in_valid && (pc == 1);
    m_ev = legal && !m_fault;
    if (legal) m_eo = ix;
    if (bus.clr) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_fault = 0; m_em = 0; m_ez = 0; m_ec = 0;
    end else if (bus.in_valid && !legal) begin
      if (pc == 0) m_ez = 1; else m_em = 1;
      m_ec = (m_ec < MAXC) ? m_ec + 1 : MAXC;
      m_fault = 1;
    end else if (legal && !m_fault) begin
      m_cnt[ix] = (m_cnt[ix] < MAXC) ? m_cnt[ix] + 1 : MAXC;
    end
    m_rv = m_pend;
    if (m_pend) m_rd = snap[m_psel];
    m_pend = bus.rd_req;
    if (bus.rd_req) m_psel = int'(bus.rd_sel);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_enc_valid", bus.enc_valid, m_ev);
    chk("m_enc_out",   bus.enc_out,   m_eo);
    chk("m_err_multi", bus.err_multi, m_em);
    chk("m_err_zero",  bus.err_zero,  m_ez);
    chk("m_err_count", bus.err_count, m_ec);
    chk("m_rd_valid",  bus.rd_valid,  m_rv);
    chk("m_rd_data",   bus.rd_data,   m_rd);
    chk("m_fault",     bus.fault,     m_fault);
  endtask

  task automatic drv(bit iv, logic [7:0] d, bit c, bit rq, logic [2:0] rs);
    bus.in_valid = iv;
    bus.dec_in   = d;
    bus.clr      = c;
    bus.rd_req   = rq;
    bus.rd_sel   = rs;
  endtask

  task automatic rd_check(string name, logic [2:0] sel, int exp);
    drv(1'b0, 8'h00, 1'b0, 1'b1, sel);
    cyc();
    drv(1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    cyc();
    chk({name, "_rd_valid"}, bus.rd_valid, 1);
    chk({name, "_rd_data"},  bus.rd_data,  exp);
  endtask

  vec_t vecs [8];
  int   exp_cnt [8];
  logic [7:0] d;
  int   r;

  initial begin
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_fault = 0; m_em = 0; m_ez = 0; m_ec = 0; m_ev = 0; m_eo = 0;
    m_rv = 0; m_rd = 0; m_pend = 0; m_psel = 0;

    vecs[0] = '{8'h02, 1}; vecs[1] = '{8'h04, 2}; vecs[2] = '{8'h20, 5}; vecs[3] = '{8'h08, 3};
    vecs[4] = '{8'h04, 2}; vecs[5] = '{8'h40, 6}; vecs[6] = '{8'h80, 7}; vecs[7] = '{8'h08, 3};
    exp_cnt = '{0, 1, 2, 2, 0, 1, 1, 1};

    // 1. reset held two cycles with a legal word present
    rst = 1'b0;
    drv(1'b1, 8'h04, 1'b0, 1'b0, 3'd0);
    cyc(); cyc();
    chk("rst_enc_valid", bus.enc_valid, 0);
    chk("rst_enc_out",   bus.enc_out,   0);
    chk("rst_fault",     bus.fault,     0);
    chk("rst_err_count", bus.err_count, 0);
    rst = 1'b1;
    drv(1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    cyc();

    // 2. legal stream, one-cycle latency, then read all counters
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, vecs[i].din, 1'b0, 1'b0, 3'd0);
      cyc();
      chk("stream_enc_valid", bus.enc_valid, 1);
      chk("stream_enc_out",   bus.enc_out,   vecs[i].exp_idx);
    end
    drv(1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    cyc();
    chk("stream_hold_enc_valid", bus.enc_valid, 0);
    chk("stream_hold_enc_out",   bus.enc_out,   3);
    for (int i = 0; i < 8; i++) rd_check("stream_cnt", 3'(i), exp_cnt[i]);

    // 3. illegal words: multi-hot enters FAULT, counting frozen, clr recovers, zero word flagged
    drv(1'b0, 8'h00, 1'b1, 1'b0, 3'd0); cyc();
    drv(1'b1, 8'h06, 1'b0, 1'b0, 3'd0); cyc();
    chk("ill_err_multi", bus.err_multi, 1);
    chk("ill_err_count", bus.err_count, 1);
    chk("ill_fault",     bus.fault,     1);
    drv(1'b1, 8'h01, 1'b0, 1'b0, 3'd0); cyc();
    chk("ill_frozen_enc_valid", bus.enc_valid, 0);
    rd_check("ill_cnt0", 3'd0, 0);
    drv(1'b0, 8'h00, 1'b1, 1'b0, 3'd0); cyc();
    chk("clr_fault",     bus.fault,     0);
    chk("clr_err_multi", bus.err_multi, 0);
    chk("clr_err_count", bus.err_count, 0);
    drv(1'b1, 8'h00, 1'b0, 1'b0, 3'd0); cyc();
    chk("zero_err_zero",  bus.err_zero,  1);
    chk("zero_err_multi", bus.err_multi, 0);
    drv(1'b0, 8'h00, 1'b1, 1'b0, 3'd0); cyc();

    // 4. saturation of a hit counter and of err_count
    for (int i = 0; i < 20; i++) begin drv(1'b1, 8'h10, 1'b0, 1'b0, 3'd0); cyc(); end
    rd_check("sat_cnt4", 3'd4, 15);
    for (int i = 0; i < 20; i++) begin drv(1'b1, 8'h03, 1'b0, 1'b0, 3'd0); cyc(); end
    chk("sat_err_count", bus.err_count, 15);
    drv(1'b0, 8'h00, 1'b1, 1'b0, 3'd0); cyc();

    // 5. back-to-back reads of sel 3 then 5 while 8'h08 streams
    drv(1'b1, 8'h20, 1'b0, 1'b0, 3'd0); cyc(); cyc();
    drv(1'b1, 8'h08, 1'b0, 1'b1, 3'd3); cyc();
    drv(1'b1, 8'h08, 1'b0, 1'b1, 3'd5); cyc();
    chk("b2b_first_valid", bus.rd_valid, 1);
    chk("b2b_first_data",  bus.rd_data,  1);
    drv(1'b1, 8'h08, 1'b0, 1'b0, 3'd0); cyc();
    chk("b2b_second_valid", bus.rd_valid, 1);
    chk("b2b_second_data",  bus.rd_data,  2);
    drv(1'b0, 8'h00, 1'b0, 1'b0, 3'd0); cyc();
    chk("b2b_idle_valid", bus.rd_valid, 0);
    chk("b2b_hold_data",  bus.rd_data,  2);

    // 6. reset right after a read request drops the read; clr beats a same-cycle hit
    drv(1'b0, 8'h00, 1'b0, 1'b1, 3'd3); cyc();
    rst = 1'b0;
    drv(1'b0, 8'h00, 1'b0, 1'b0, 3'd0); cyc();
    chk("midrst_rd_valid", bus.rd_valid, 0);
    rst = 1'b1;
    cyc();
    chk("midrst_rd_valid_after", bus.rd_valid, 0);
    rd_check("midrst_cnt3", 3'd3, 0);
    rd_check("midrst_cnt5", 3'd5, 0);
    drv(1'b1, 8'h08, 1'b0, 1'b0, 3'd0); cyc();
    drv(1'b1, 8'h08, 1'b1, 1'b1, 3'd3); cyc();
    drv(1'b0, 8'h00, 1'b0, 1'b0, 3'd0); cyc();
    chk("clr_rd_same_cycle", bus.rd_data, 0);
    rd_check("clr_vs_hit_cnt3", 3'd3, 0);

    // 7. randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(99);
      if (r < 70)      d = 8'h01 << $urandom_range(7);
      else if (r < 85) d = 8'h00;
      else begin
        d = 8'($urandom_range(255));
        if ($countones(d) < 2) d = d | 8'h81 | (8'h01 << $urandom_range(6, 1));
      end
      rst = ($urandom_range(99) != 0);
      drv(($urandom_range(3) != 0), d, ($urandom_range(24) == 0),
          ($urandom_range(2) == 0), 3'($urandom_range(7)));
      cyc();
    end
    rst = 1'b1;
    drv(1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
